// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types and constants for the two-requester bus arbiter.
// Revision : 1.0  initial release
// ============================================================================
package arb_pkg;

    localparam int MEM_AW = 16;
    localparam int MEM_DW = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick
// Brief    : Combinational winner select. ARB_ROUND_ROBIN_EN selects
//            round-robin tie-break; otherwise requester 0 has fixed priority.
// Revision : 1.0  initial release
// ============================================================================
module arb_pick
    import arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       owner,
    input  logic       retain,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       ptr,
`endif
    output logic [1:0] winner
);

    always_comb begin
        winner = 2'b00;
        if (retain) begin
            winner = onehot2(owner);
        end else if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
            // ptr names the requester that did not own the previous beat
            winner = onehot2(ptr);
`else
            winner = 2'b01;
`endif
        end else begin
            winner = req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Brief    : Two-requester single-beat memory bus arbiter with lock bursts.
//            Build macro ARB_ROUND_ROBIN_EN enables round-robin tie-break.
// Revision : 1.0  initial release
// ============================================================================
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [MEM_AW-1:0] addr0,
    input  logic [MEM_AW-1:0] addr1,
    input  logic [MEM_DW-1:0] wdata0,
    input  logic [MEM_DW-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [MEM_DW-1:0] rdata0,
    output logic [MEM_DW-1:0] rdata1,
    output logic              mem_write,
    output logic              mem_read,
    output logic [MEM_AW-1:0] mem_address,
    output logic [MEM_DW-1:0] mem_dout,
    input  logic [MEM_DW-1:0] mem_din
);

    localparam logic [2:0] c_burst_max = 3'(BURST_MAX);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic [1:0]        r_gnt;
    logic [1:0]        r_ack;
    logic              r_owner;
    logic              r_we;
    logic [MEM_AW-1:0] r_addr;
    logic [MEM_DW-1:0] r_wdata;
    logic [MEM_DW-1:0] r_rdata0;
    logic [MEM_DW-1:0] r_rdata1;
    logic [2:0]        r_count;
    logic [1:0]        w_req;
    logic [1:0]        w_winner;
    logic              w_win_idx;
    logic              w_retain;

    assign w_req     = {req1, req0};
    assign w_win_idx = w_winner[1];
    assign w_retain  = (r_state == COMPLETE)
                     && (r_owner ? (req1 && lock1) : (req0 && lock0))
                     && (r_count < c_burst_max);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_ptr;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 1'b0;
        end else if ((r_state != ACCESS) && (|w_req)) begin
            r_ptr <= ~w_win_idx;
        end
    end

    arb_pick u_pick (
        .req    (w_req),
        .owner  (r_owner),
        .retain (w_retain),
        .ptr    (r_ptr),
        .winner (w_winner)
    );
`else
    arb_pick u_pick (
        .req    (w_req),
        .owner  (r_owner),
        .retain (w_retain),
        .winner (w_winner)
    );
`endif

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, COMPLETE: w_state_next = (|w_req) ? ACCESS : IDLE;
            ACCESS:         w_state_next = COMPLETE;
            default:        w_state_next = IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt    <= 2'b00;
            r_ack    <= 2'b00;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_count  <= 3'd0;
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                IDLE, COMPLETE: begin
                    if (|w_req) begin
                        r_gnt   <= w_winner;
                        r_owner <= w_win_idx;
                        r_we    <= w_win_idx ? we1    : we0;
                        r_addr  <= w_win_idx ? addr1  : addr0;
                        r_wdata <= w_win_idx ? wdata1 : wdata0;
                        // retention only happens below BURST_MAX, so no wrap
                        r_count <= w_retain ? (r_count + 3'd1) : 3'd1;
                    end else begin
                        r_gnt <= 2'b00;
                    end
                end
                ACCESS: begin
                    r_ack <= onehot2(r_owner);
                    if (r_owner) begin
                        r_rdata1 <= mem_din;
                    end else begin
                        r_rdata0 <= mem_din;
                    end
                end
                default: r_gnt <= 2'b00;
            endcase
        end
    end

    // strobes decode the state directly so reset removes them at once
    assign mem_write   = (r_state == ACCESS) &&  r_we;
    assign mem_read    = (r_state == ACCESS) && !r_we;
    assign mem_address = r_addr;
    assign mem_dout    = r_wdata;
    assign gnt0        = r_gnt[0];
    assign gnt1        = r_gnt[1];
    assign ack0        = r_ack[0];
    assign ack1        = r_ack[1];
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Scoreboard bench for bus_arbiter (ARB_ROUND_ROBIN_EN aware).
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, we0 = 0, we1 = 0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, ack0, ack1, mem_write, mem_read;
    logic [7:0]  rdata0, rdata1, mem_dout, mem_din;
    logic [15:0] mem_address;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        owner;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        chk_rdata;
    } beat_t;

    beat_t exp_mem[$];
    beat_t exp_ack[$];

    bus_arbiter #(.BURST_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_address(mem_address), .mem_dout(mem_dout), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    // memory model: 16'h1234 reads back 8'hA5
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h83;
    endfunction

    assign mem_din = mem_f(mem_address);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_beat(input logic owner, input logic we, input logic [15:0] addr,
                             input logic [7:0] wdata);
        beat_t b;
        b.owner = owner; b.we = we; b.addr = addr; b.wdata = wdata;
        b.rdata = mem_f(addr); b.chk_rdata = !we;
        exp_mem.push_back(b);
        exp_ack.push_back(b);
    endtask

    task automatic wait_acks(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            @(posedge clk);
            cyc++;
            if (ack0 || ack1) got++;
        end
        if (got < n) begin
            failures++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", got, n);
        end
    endtask

    // monitor: pops expectations whenever the DUT strobes memory or acks
    always @(posedge clk) begin
        beat_t e;
        if (rst) begin
            checks++;
            if (gnt0 && gnt1) begin
                failures++;
                $display("FAIL gnt_onehot: got gnt=%b%b expected at most one", gnt1, gnt0);
            end
            if (mem_write || mem_read) begin
                checks++;
                if (exp_mem.size() == 0) begin
                    failures++;
                    $display("FAIL mem_unexpected: got strobe w=%b r=%b expected none", mem_write, mem_read);
                end else begin
                    e = exp_mem.pop_front();
                    if ({mem_write, mem_read} !== {e.we, !e.we} || mem_address !== e.addr
                        || {gnt1, gnt0} !== (e.owner ? 2'b10 : 2'b01)
                        || (e.we && mem_dout !== e.wdata)) begin
                        failures++;
                        $display("FAIL mem_beat: got w=%b r=%b a=%h d=%h gnt=%b%b expected we=%b a=%h d=%h owner=%0d",
                                 mem_write, mem_read, mem_address, mem_dout, gnt1, gnt0,
                                 e.we, e.addr, e.wdata, e.owner);
                    end
                end
            end
            if (ack0 || ack1) begin
                checks++;
                if (exp_ack.size() == 0) begin
                    failures++;
                    $display("FAIL ack_unexpected: got ack=%b%b expected none", ack1, ack0);
                end else begin
                    e = exp_ack.pop_front();
                    if ({ack1, ack0} !== (e.owner ? 2'b10 : 2'b01)
                        || {gnt1, gnt0} !== (e.owner ? 2'b10 : 2'b01)
                        || (e.chk_rdata && (e.owner ? rdata1 : rdata0) !== e.rdata)) begin
                        failures++;
                        $display("FAIL ack_beat: got ack=%b%b gnt=%b%b rd0=%h rd1=%h expected owner=%0d rdata=%h",
                                 ack1, ack0, gnt1, gnt0, rdata0, rdata1, e.owner, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic own3[4];
        logic own4[6];
`ifdef ARB_ROUND_ROBIN_EN
        own3 = '{1'b0, 1'b1, 1'b0, 1'b1};
        own4 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        own3 = '{1'b0, 1'b0, 1'b0, 1'b0};
        own4 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_ack",   {30'd0, ack1, ack0}, 32'd0);
        chk("rst_strobe", {30'd0, mem_write, mem_read}, 32'd0);
        chk("rst_addr",  {16'd0, mem_address}, 32'd0);
        chk("rst_dout",  {24'd0, mem_dout}, 32'd0);
        chk("rst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
        rst = 1'b1;

        // read beat on requester 0 with explicit cycle-by-cycle timing
        @(posedge clk); #1;
        req0 = 1; we0 = 0; addr0 = 16'h1234;
        push_beat(1'b0, 1'b0, 16'h1234, 8'h00);
        @(posedge clk);
        chk("rd_strobe_cycle", {31'd0, mem_read}, 32'd1);
        @(posedge clk);
        chk("rd_ack_cycle", {30'd0, ack1, ack0}, 32'd1);
        chk("rd_rdata0", {24'd0, rdata0}, 32'h0000_00A5);
        #1 req0 = 0;

        // write beat on requester 1
        @(posedge clk); #1;
        req1 = 1; we1 = 1; addr1 = 16'h00F0; wdata1 = 8'h3C;
        push_beat(1'b1, 1'b1, 16'h00F0, 8'h3C);
        wait_acks(1, 20);
        #1 req1 = 0; we1 = 0;
        @(posedge clk);
        chk("wr_rdata0_kept", {24'd0, rdata0}, 32'h0000_00A5);

        // simultaneous requests, four beats, no lock
        #1;
        addr0 = 16'h0102; addr1 = 16'h0304;
        for (int i = 0; i < 4; i++)
            push_beat(own3[i], 1'b0, own3[i] ? 16'h0304 : 16'h0102, 8'h00);
        req0 = 1; req1 = 1;
        wait_acks(4, 40);
        #1 req0 = 0; req1 = 0;
        @(posedge clk);

        // lock burst on requester 0 with requester 1 contending
        #1;
        for (int i = 0; i < 6; i++)
            push_beat(own4[i], 1'b0, own4[i] ? 16'h0304 : 16'h0102, 8'h00);
        req0 = 1; lock0 = 1; req1 = 1;
        wait_acks(6, 60);
        #1 req0 = 0; lock0 = 0; req1 = 0;
        @(posedge clk);

        // reset during the ACCESS cycle of a write
        #1;
        req0 = 1; we0 = 1; addr0 = 16'hBEEF; wdata0 = 8'h77;
        exp_mem.push_back('{owner: 1'b0, we: 1'b1, addr: 16'hBEEF, wdata: 8'h77,
                            rdata: 8'h00, chk_rdata: 1'b0});
        @(posedge clk);
        #1;
        rst = 0; req0 = 0; we0 = 0;
        #1;
        chk("rstmid_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rstmid_gnt0", {31'd0, gnt0}, 32'd0);
        @(posedge clk);
        chk("rstmid_no_ack", {30'd0, ack1, ack0}, 32'd0);
        #1 rst = 1;
        repeat (4) @(posedge clk);
        chk("post_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("post_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("post_strobe", {30'd0, mem_write, mem_read}, 32'd0);
        chk("post_addr_dout", {8'd0, mem_address, mem_dout}, 32'd0);
        chk("post_rdata", {16'd0, rdata1, rdata0}, 32'd0);
        chk("sb_mem_empty", exp_mem.size(), 32'd0);
        chk("sb_ack_empty", exp_ack.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
